// File: rtl/unified_mem_arbiter.sv
// unified_mem_arbiter
//   Shares one single-ported, variable-latency memory between the core's fetch
//   port (I) and data port (D). Each access is a request/ready transaction on
//   the memory side; completion returns read data with a one-cycle valid pulse
//   on the owning port. D has priority; a starvation counter forces an I grant
//   after STARVE_LIMIT consecutive D grants made while I was waiting.
// Ports
//   clk, reset                  clock (rising), async active-low reset
//   IReq/IAdr -> IRData/IValid  fetch port
//   DReq/DAdr/DWData/DWe -> DRData/DValid  data port
//   MemReq/MemAdr/MemWData/MemWe, MemRData/MemReady  memory side
//   StallIF/StallMEM            stall requests to the hazard unit
//   Owner                       0 = fetch or idle, 1 = data owns memory
module unified_mem_arbiter #(
    parameter int AW           = 32,
    parameter int DW           = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          IReq,
    input  logic [AW-1:0] IAdr,
    output logic [DW-1:0] IRData,
    output logic          IValid,
    input  logic          DReq,
    input  logic [AW-1:0] DAdr,
    input  logic [DW-1:0] DWData,
    input  logic          DWe,
    output logic [DW-1:0] DRData,
    output logic          DValid,
    output logic          MemReq,
    output logic [AW-1:0] MemAdr,
    output logic [DW-1:0] MemWData,
    output logic          MemWe,
    input  logic [DW-1:0] MemRData,
    input  logic          MemReady,
    output logic          StallIF,
    output logic          StallMEM,
    output logic          Owner
);
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] I_WAIT = 2'd1;
    localparam logic [1:0] D_WAIT = 2'd2;

    localparam int CW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(STARVE_LIMIT);

    logic [1:0]    state;
    logic [CW-1:0] cnt;

    logic elig_i, elig_d, done, arb, cand_i, cand_d, grant_i, grant_d;

    // A port whose valid pulse is out this cycle has already been served.
    assign elig_i = IReq & ~IValid;
    assign elig_d = DReq & ~DValid;

    // MemReady only means something while a transaction is open.
    assign done = (state != IDLE) & MemReady;
    assign arb  = (state == IDLE) | done;

    // The port completing this edge is excluded so the other one gets a
    // back-to-back grant with no idle bubble.
    assign cand_i = elig_i & ~(done & (state == I_WAIT));
    assign cand_d = elig_d & ~(done & (state == D_WAIT));

    assign grant_d = arb & cand_d & ((cnt < CNT_MAX) | ~cand_i);
    assign grant_i = arb & cand_i & ~grant_d;

    assign StallIF  = elig_i;
    assign StallMEM = elig_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            cnt      <= '0;
            MemReq   <= 1'b0;
            MemAdr   <= '0;
            MemWData <= '0;
            MemWe    <= 1'b0;
            Owner    <= 1'b0;
            IValid   <= 1'b0;
            DValid   <= 1'b0;
            IRData   <= '0;
            DRData   <= '0;
        end else begin
            IValid <= done & (state == I_WAIT);
            DValid <= done & (state == D_WAIT);
            if (done && state == I_WAIT)
                IRData <= MemRData;
            // Stores leave the load-data register alone.
            if (done && state == D_WAIT && !MemWe)
                DRData <= MemRData;

            if (grant_d) begin
                state    <= D_WAIT;
                MemReq   <= 1'b1;
                MemAdr   <= DAdr;
                MemWData <= DWData;
                MemWe    <= DWe;
                Owner    <= 1'b1;
                // Count only D grants that made a waiting fetch wait longer.
                if (!cand_i)
                    cnt <= '0;
                else if (cnt != CNT_MAX)
                    cnt <= cnt + CW'(1);
            end else if (grant_i) begin
                state    <= I_WAIT;
                MemReq   <= 1'b1;
                MemAdr   <= IAdr;
                MemWData <= '0;
                MemWe    <= 1'b0;
                Owner    <= 1'b0;
                cnt      <= '0;
            end else if (arb) begin
                state  <= IDLE;
                MemReq <= 1'b0;
                MemWe  <= 1'b0;
                Owner  <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Self-checking bench for unified_mem_arbiter: directed scenarios with literal
// expectations, then randomized core/memory traffic compared every cycle
// against a transaction-level model of the arbitration rules.
module tb_unified_mem_arbiter;
    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int LIM = 4;

    logic clk = 0, reset = 0;
    logic IReq = 0, DReq = 0, DWe = 0, MemReady = 0;
    logic [AW-1:0] IAdr = '0, DAdr = '0;
    logic [DW-1:0] DWData = '0, MemRData = '0;
    logic [DW-1:0] IRData, DRData, MemWData;
    logic [AW-1:0] MemAdr;
    logic IValid, DValid, MemReq, MemWe, StallIF, StallMEM, Owner;

    always #5 clk = ~clk;

    unified_mem_arbiter #(.AW(AW), .DW(DW), .STARVE_LIMIT(LIM)) dut (
        .clk(clk), .reset(reset),
        .IReq(IReq), .IAdr(IAdr), .IRData(IRData), .IValid(IValid),
        .DReq(DReq), .DAdr(DAdr), .DWData(DWData), .DWe(DWe),
        .DRData(DRData), .DValid(DValid),
        .MemReq(MemReq), .MemAdr(MemAdr), .MemWData(MemWData), .MemWe(MemWe),
        .MemRData(MemRData), .MemReady(MemReady),
        .StallIF(StallIF), .StallMEM(StallMEM), .Owner(Owner)
    );

    int tests = 0, fails = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // One open transaction at most; who owns it, what it carries, and what
    // the ports saw last cycle. Grants follow the priority/starvation rule.
    bit            m_busy, m_owner, m_we, m_ival, m_dval;
    logic [AW-1:0] m_adr;
    logic [DW-1:0] m_wd, m_ird, m_drd;
    int            m_cnt;
    bit            g_log[$];   // 1 = D grant, 0 = I grant
    bit            e_i, e_d, srv;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_busy = 0; m_owner = 0; m_we = 0; m_ival = 0; m_dval = 0;
            m_adr = '0; m_wd = '0; m_ird = '0; m_drd = '0; m_cnt = 0;
        end else begin
            e_i = IReq && !m_ival;
            e_d = DReq && !m_dval;
            m_ival = 0; m_dval = 0; srv = 0;
            if (m_busy && MemReady) begin
                srv = 1;
                if (m_owner) begin
                    m_dval = 1; e_d = 0;
                    if (!m_we) m_drd = MemRData;
                end else begin
                    m_ival = 1; e_i = 0; m_ird = MemRData;
                end
            end
            if (!m_busy || srv) begin
                if (e_d && (m_cnt < LIM || !e_i)) begin
                    m_busy = 1; m_owner = 1; m_adr = DAdr; m_wd = DWData; m_we = DWe;
                    m_cnt = e_i ? ((m_cnt + 1 > LIM) ? LIM : m_cnt + 1) : 0;
                    g_log.push_back(1'b1);
                end else if (e_i) begin
                    m_busy = 1; m_owner = 0; m_adr = IAdr; m_wd = '0; m_we = 0;
                    m_cnt = 0;
                    g_log.push_back(1'b0);
                end else begin
                    m_busy = 0; m_owner = 0; m_we = 0;
                end
            end
        end
    end

    // Per-cycle compare, away from the active edge.
    always @(negedge clk) begin
        chk("MemReq",   MemReq,   m_busy);
        chk("MemAdr",   MemAdr,   m_adr);
        chk("MemWData", MemWData, m_wd);
        chk("MemWe",    MemWe,    m_we);
        chk("Owner",    Owner,    m_owner);
        chk("IValid",   IValid,   m_ival);
        chk("DValid",   DValid,   m_dval);
        chk("IRData",   IRData,   m_ird);
        chk("DRData",   DRData,   m_drd);
        chk("StallIF",  StallIF,  IReq && !m_ival);
        chk("StallMEM", StallMEM, DReq && !m_dval);
    end

    task automatic step();
        @(posedge clk); #2;
    endtask

    int n_stall, n_req, n_dv, gbase;

    initial begin
        // Reset state.
        #7;
        chk("rst_MemReq", MemReq, 0);
        chk("rst_Owner",  Owner,  0);
        chk("rst_MemAdr", MemAdr, 0);
        step(); step();
        reset = 1;
        step();

        // Fetch only, minimum latency.
        IReq = 1; IAdr = 32'h10; MemReady = 1; MemRData = 32'hE3A01005;
        @(negedge clk); chk("t1_noreq_N", MemReq, 0);
        step();
        @(negedge clk); chk("t1_MemReq", MemReq, 1); chk("t1_MemAdr", MemAdr, 32'h10);
        step();
        @(negedge clk); chk("t1_IValid", IValid, 1); chk("t1_IRData", IRData, 32'hE3A01005);
        IReq = 0;
        step();
        @(negedge clk); chk("t1_StallIF", StallIF, 0); chk("t1_IValid_off", IValid, 0);
        step();

        // Simultaneous I and D: D first, I back-to-back.
        gbase = g_log.size();
        IReq = 1; IAdr = 32'h14; DReq = 1; DAdr = 32'h80; DWe = 0;
        step();
        @(negedge clk); chk("t2_Owner_D", Owner, 1); chk("t2_Adr_D", MemAdr, 32'h80);
        chk("t2_StallIF", StallIF, 1);
        step();
        DReq = 0;
        @(negedge clk); chk("t2_DValid", DValid, 1); chk("t2_MemReq_b2b", MemReq, 1);
        chk("t2_Owner_I", Owner, 0); chk("t2_Adr_I", MemAdr, 32'h14);
        chk("t2_StallIF2", StallIF, 1);
        step();
        @(negedge clk); chk("t2_IValid", IValid, 1); chk("t2_StallIF_off", StallIF, 0);
        chk("t2_order0", g_log[gbase], 1); chk("t2_order1", g_log[gbase+1], 0);
        IReq = 0;
        step(); step();

        // Load with three wait cycles.
        DReq = 1; DAdr = 32'h90; DWe = 0; MemReady = 0; MemRData = 32'h0BADF00D;
        n_stall = 0; n_req = 0; n_dv = 0;
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            n_stall += StallMEM; n_req += MemReq; n_dv += DValid;
            step();
            if (k == 3) MemReady = 1;
            if (k == 4) begin DReq = 0; MemReady = 0; end
        end
        chk("t3_stall_cycles", n_stall, 5);
        chk("t3_req_cycles", n_req, 4);
        chk("t3_dvalid_pulses", n_dv, 1);
        chk("t3_DRData", DRData, 32'h0BADF00D);

        // Store leaves DRData unchanged.
        MemReady = 1; MemRData = 32'h12345678;
        DReq = 1; DWe = 1; DAdr = 32'h40; DWData = 32'hDEADBEEF;
        step();
        @(negedge clk); chk("t5_MemWe", MemWe, 1); chk("t5_MemWData", MemWData, 32'hDEADBEEF);
        chk("t5_MemAdr", MemAdr, 32'h40);
        step();
        @(negedge clk); chk("t5_DValid", DValid, 1); chk("t5_DRData", DRData, 32'h0BADF00D);
        DReq = 0; DWe = 0;
        step(); step();

        // Reset mid D_WAIT, then pending fetch served with normal latency.
        MemReady = 0; DReq = 1; DAdr = 32'h84;
        step(); step();
        IReq = 1; IAdr = 32'h20;
        step();
        reset = 0; DReq = 0;
        #1;
        chk("t6_MemReq", MemReq, 0); chk("t6_Owner", Owner, 0);
        chk("t6_MemAdr", MemAdr, 0); chk("t6_DValid", DValid, 0);
        step();
        reset = 1; MemReady = 1; MemRData = 32'hCAFE0001;
        step();
        @(negedge clk); chk("t6_MemReq_I", MemReq, 1); chk("t6_MemAdr_I", MemAdr, 32'h20);
        step();
        @(negedge clk); chk("t6_IValid", IValid, 1); chk("t6_IRData", IRData, 32'hCAFE0001);
        IReq = 0;
        step();

        // Randomized traffic: ports hold requests until their valid pulse.
        for (int c = 0; c < 4000; c++) begin
            if (c == 2000) begin
                reset = 0; IReq = 0; DReq = 0;
                step(); step();
                reset = 1;
            end
            if (IValid || !IReq) begin
                IReq = ($urandom_range(0, 3) != 0);
                IAdr = $urandom & 32'hFFFF_FFFC;
            end
            if (DValid || !DReq) begin
                DReq   = ($urandom_range(0, 2) != 0);
                DAdr   = $urandom;
                DWData = $urandom;
                DWe    = $urandom_range(0, 1);
            end
            MemReady = ($urandom_range(0, 2) != 0);
            MemRData = $urandom;
            step();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
